// File: rtl/regfile_arb_pkg.sv
// ============================================================================
// Package     : regfile_arb_pkg
// Description : Shared widths and requester indices for the register-file
//               write-port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_arb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam int ZERO_REG   = 0;

  typedef logic req_idx_t;

  localparam req_idx_t REQ_ALU = 1'b0;
  localparam req_idx_t REQ_MEM = 1'b1;

endpackage : regfile_arb_pkg

`default_nettype wire

// File: rtl/arb_input_buffer.sv
// ============================================================================
// Module      : arb_input_buffer
// Description : One-entry writeback buffer; accepts when empty or draining,
//               silently drops writes aimed at x0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_input_buffer
  import regfile_arb_pkg::*;
#(
  parameter int DATA_W = XLEN,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ready_o,
  input  logic              drain_i,
  output logic              buf_valid_o,
  output logic [ADDR_W-1:0] buf_addr_o,
  output logic [DATA_W-1:0] buf_data_o
);

  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              load;

  assign ready_o = ~valid_q | drain_i;
  assign load    = valid_i & ready_o & (addr_i != ADDR_W'(ZERO_REG));

  // A load in the draining cycle overwrites the entry, so there is no bubble.
  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      addr_d  = addr_i;
      data_d  = data_i;
    end else if (drain_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign buf_valid_o = valid_q;
  assign buf_addr_o  = addr_q;
  assign buf_data_o  = data_q;

endmodule : arb_input_buffer

`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
// ============================================================================
// Module      : regfile_write_arbiter
// Description : Shares the register-file write port between ALU and load
//               writeback, and flags read-after-write hazards.
//               Macro RF_ARB_ROUND_ROBIN_EN selects round-robin arbitration;
//               fixed ALU priority otherwise.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_write_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int DATA_W = XLEN,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] write_reg_address,
  output logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] read_reg_address_1,
  input  logic [ADDR_W-1:0] read_reg_address_2,
  output logic              hazard_1,
  output logic              hazard_2,
  output logic              busy
);

  logic [1:0]        buf_valid;
  logic [1:0]        grant;
  logic [ADDR_W-1:0] buf0_addr, buf1_addr;
  logic [DATA_W-1:0] buf0_data, buf1_data;

  logic              regwrite_q, regwrite_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  arb_input_buffer #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_buf_alu (
    .clk         (clk),
    .reset       (reset),
    .valid_i     (req0_valid),
    .addr_i      (req0_addr),
    .data_i      (req0_data),
    .ready_o     (req0_ready),
    .drain_i     (grant[REQ_ALU]),
    .buf_valid_o (buf_valid[REQ_ALU]),
    .buf_addr_o  (buf0_addr),
    .buf_data_o  (buf0_data)
  );

  arb_input_buffer #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_buf_mem (
    .clk         (clk),
    .reset       (reset),
    .valid_i     (req1_valid),
    .addr_i      (req1_addr),
    .data_i      (req1_data),
    .ready_o     (req1_ready),
    .drain_i     (grant[REQ_MEM]),
    .buf_valid_o (buf_valid[REQ_MEM]),
    .buf_addr_o  (buf1_addr),
    .buf_data_o  (buf1_data)
  );

`ifdef RF_ARB_ROUND_ROBIN_EN
  req_idx_t last_grant_q, last_grant_d;

  // On contention, favour whichever requester was not served last.
  always_comb begin
    grant        = buf_valid;
    last_grant_d = last_grant_q;
    if (&buf_valid) begin
      grant = (last_grant_q == REQ_ALU) ? 2'b10 : 2'b01;
    end
    if (grant[REQ_MEM]) begin
      last_grant_d = REQ_MEM;
    end else if (grant[REQ_ALU]) begin
      last_grant_d = REQ_ALU;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= REQ_MEM;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`else
  always_comb begin
    grant = {buf_valid[REQ_MEM] & ~buf_valid[REQ_ALU], buf_valid[REQ_ALU]};
  end
`endif

  always_comb begin
    regwrite_d = |grant;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    if (grant[REQ_ALU]) begin
      waddr_d = buf0_addr;
      wdata_d = buf0_data;
    end else if (grant[REQ_MEM]) begin
      waddr_d = buf1_addr;
      wdata_d = buf1_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regwrite_q <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      regwrite_q <= regwrite_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign RegWrite          = regwrite_q;
  assign write_reg_address = waddr_q;
  assign write_data        = wdata_q;

  // A write is pending while it sits in either buffer or on the write port.
  function automatic logic pending_write(input logic [ADDR_W-1:0] raddr);
    return (raddr != ADDR_W'(ZERO_REG)) &
           ((buf_valid[REQ_ALU] & (buf0_addr == raddr)) |
            (buf_valid[REQ_MEM] & (buf1_addr == raddr)) |
            (regwrite_q & (waddr_q == raddr)));
  endfunction

  assign hazard_1 = pending_write(read_reg_address_1);
  assign hazard_2 = pending_write(read_reg_address_2);
  assign busy     = (|buf_valid) | regwrite_q;

endmodule : regfile_write_arbiter

`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
// ============================================================================
// Module      : tb_regfile_write_arbiter
// Description : Self-checking bench for regfile_write_arbiter: vector table,
//               streaming/fairness sequences and random traffic vs a model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [4:0]  req0_addr, req1_addr;
  logic [31:0] req0_data, req1_data;
  logic        RegWrite;
  logic [4:0]  write_reg_address;
  logic [31:0] write_data;
  logic [4:0]  read_reg_address_1, read_reg_address_2;
  logic        hazard_1, hazard_2, busy;

  always #5 clk = ~clk;

  regfile_write_arbiter #(
    .DATA_W (32),
    .ADDR_W (5)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .req0_valid         (req0_valid),
    .req0_ready         (req0_ready),
    .req0_addr          (req0_addr),
    .req0_data          (req0_data),
    .req1_valid         (req1_valid),
    .req1_ready         (req1_ready),
    .req1_addr          (req1_addr),
    .req1_data          (req1_data),
    .RegWrite           (RegWrite),
    .write_reg_address  (write_reg_address),
    .write_data         (write_data),
    .read_reg_address_1 (read_reg_address_1),
    .read_reg_address_2 (read_reg_address_2),
    .hazard_1           (hazard_1),
    .hazard_2           (hazard_2),
    .busy               (busy)
  );

  typedef struct {
    logic [31:0] rst, v0, a0, d0, v1, a1, d1, ra1, ra2;
    logic [31:0] we, wa, wd, r0, r1, h1, h2, bz;
  } vec_t;

  vec_t tbl[20];

  int total = 0;
  int bad   = 0;

  // Reference model: buffer contents, write port and a shadow register file.
  logic        mv[2];
  logic [4:0]  ma[2];
  logic [31:0] md[2];
  logic        mwe;
  logic [4:0]  mwa;
  logic [31:0] mwd;
`ifdef RF_ARB_ROUND_ROBIN_EN
  logic        mlast;
`endif
  logic [31:0] rf_ref[32];
  logic [31:0] rf_dut[32];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int pick();
    if (mv[0] && mv[1]) begin
`ifdef RF_ARB_ROUND_ROBIN_EN
      return mlast ? 0 : 1;
`else
      return 0;
`endif
    end
    if (mv[0]) return 0;
    if (mv[1]) return 1;
    return -1;
  endfunction

  function automatic logic pend(input logic [4:0] ra);
    return (ra != 5'd0) && ((mv[0] && ma[0] == ra) || (mv[1] && ma[1] == ra) ||
                            (mwe && mwa == ra));
  endfunction

  task automatic drive(input logic rst, input logic v0, input logic [4:0] a0,
                       input logic [31:0] d0, input logic v1, input logic [4:0] a1,
                       input logic [31:0] d1, input logic [4:0] r1, input logic [4:0] r2);
    reset = rst;
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    read_reg_address_1 = r1;
    read_reg_address_2 = r2;
  endtask

  task automatic check_model(input string tag);
    int g;
    g = pick();
    chk({tag, ".we"},     {31'b0, RegWrite}, {31'b0, mwe});
    chk({tag, ".waddr"},  {27'b0, write_reg_address}, {27'b0, mwa});
    chk({tag, ".wdata"},  write_data, mwd);
    chk({tag, ".ready0"}, {31'b0, req0_ready}, {31'b0, (!mv[0] || g == 0)});
    chk({tag, ".ready1"}, {31'b0, req1_ready}, {31'b0, (!mv[1] || g == 1)});
    chk({tag, ".haz1"},   {31'b0, hazard_1}, {31'b0, pend(read_reg_address_1)});
    chk({tag, ".haz2"},   {31'b0, hazard_2}, {31'b0, pend(read_reg_address_2)});
    chk({tag, ".busy"},   {31'b0, busy}, {31'b0, (mv[0] || mv[1] || mwe)});
  endtask

  // Called between edges: advances the model across the next posedge.
  task automatic tick();
    int   g;
    logic rdy0, rdy1;
    g    = pick();
    rdy0 = !mv[0] || (g == 0);
    rdy1 = !mv[1] || (g == 1);
    if (mwe) rf_ref[mwa] = mwd;
    if (RegWrite === 1'b1) rf_dut[write_reg_address] = write_data;
    @(posedge clk);
    if (reset) begin
      mv[0] = 1'b0; mv[1] = 1'b0;
      mwe = 1'b0; mwa = '0; mwd = '0;
`ifdef RF_ARB_ROUND_ROBIN_EN
      mlast = 1'b1;
`endif
    end else begin
      if (g >= 0) begin
        mwe = 1'b1; mwa = ma[g]; mwd = md[g]; mv[g] = 1'b0;
`ifdef RF_ARB_ROUND_ROBIN_EN
        mlast = (g == 1);
`endif
      end else begin
        mwe = 1'b0;
      end
      if (req0_valid && rdy0 && req0_addr != 5'd0) begin
        mv[0] = 1'b1; ma[0] = req0_addr; md[0] = req0_data;
      end
      if (req1_valid && rdy1 && req1_addr != 5'd0) begin
        mv[1] = 1'b1; ma[1] = req1_addr; md[1] = req1_data;
      end
    end
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  wq[$];
    int          i0, i1;
    logic        hs0, hs1;
    logic [31:0] exp_a;

    //            rst v0 a0  d0            v1 a1 d1       ra1 ra2 | we wa wd           r0 r1 h1 h2 bz
    tbl[0]  = '{0, 0, 0, 0,            0, 0, 0,        0, 0,   0, 0, 0,            1, 1, 0, 0, 0};
    tbl[1]  = '{0, 1, 5, 32'hDEADBEEF, 0, 0, 0,        5, 0,   0, 0, 0,            1, 1, 0, 0, 0};
    tbl[2]  = '{0, 0, 0, 0,            0, 0, 0,        5, 0,   0, 0, 0,            1, 1, 1, 0, 1};
    tbl[3]  = '{0, 0, 0, 0,            0, 0, 0,        5, 0,   1, 5, 32'hDEADBEEF, 1, 1, 1, 0, 1};
    tbl[4]  = '{0, 0, 0, 0,            0, 0, 0,        5, 5,   0, 5, 32'hDEADBEEF, 1, 1, 0, 0, 0};
    tbl[5]  = '{0, 0, 0, 0,            1, 0, 32'h1234, 0, 0,   0, 5, 32'hDEADBEEF, 1, 1, 0, 0, 0};
    tbl[6]  = '{0, 0, 0, 0,            0, 0, 0,        0, 0,   0, 5, 32'hDEADBEEF, 1, 1, 0, 0, 0};
    tbl[7]  = '{0, 1, 3, 32'h11,       1, 4, 32'h22,   3, 4,   0, 5, 32'hDEADBEEF, 1, 1, 0, 0, 0};
    tbl[8]  = '{0, 0, 0, 0,            0, 0, 0,        3, 4,   0, 5, 32'hDEADBEEF, 1, 0, 1, 1, 1};
    tbl[9]  = '{0, 0, 0, 0,            0, 0, 0,        3, 4,   1, 3, 32'h11,       1, 1, 1, 1, 1};
    tbl[10] = '{0, 0, 0, 0,            0, 0, 0,        3, 4,   1, 4, 32'h22,       1, 1, 0, 1, 1};
    tbl[11] = '{0, 0, 0, 0,            0, 0, 0,        3, 4,   0, 4, 32'h22,       1, 1, 0, 0, 0};
    tbl[12] = '{0, 1, 7, 32'h77,       1, 8, 32'h88,   0, 0,   0, 4, 32'h22,       1, 1, 0, 0, 0};
    tbl[13] = '{1, 0, 0, 0,            0, 0, 0,        7, 8,   0, 4, 32'h22,       1, 0, 1, 1, 1};
    tbl[14] = '{0, 0, 0, 0,            0, 0, 0,        7, 8,   0, 0, 0,            1, 1, 0, 0, 0};
    tbl[15] = '{0, 1, 9, 32'h99,       0, 0, 0,        0, 9,   0, 0, 0,            1, 1, 0, 0, 0};
    tbl[16] = '{0, 1, 9, 32'hAA,       0, 0, 0,        0, 9,   0, 0, 0,            1, 1, 0, 1, 1};
    tbl[17] = '{0, 0, 0, 0,            0, 0, 0,        0, 9,   1, 9, 32'h99,       1, 1, 0, 1, 1};
    tbl[18] = '{0, 0, 0, 0,            0, 0, 0,        0, 9,   1, 9, 32'hAA,       1, 1, 0, 1, 1};
    tbl[19] = '{0, 0, 0, 0,            0, 0, 0,        0, 0,   0, 9, 32'hAA,       1, 1, 0, 0, 0};

    mv[0] = 1'b0; mv[1] = 1'b0; ma[0] = '0; ma[1] = '0; md[0] = '0; md[1] = '0;
    mwe = 1'b0; mwa = '0; mwd = '0;
    for (int r = 0; r < 32; r++) begin
      rf_ref[r] = '0;
      rf_dut[r] = '0;
    end

    drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    tick();
    tick();

    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].rst[0], tbl[i].v0[0], tbl[i].a0[4:0], tbl[i].d0, tbl[i].v1[0],
            tbl[i].a1[4:0], tbl[i].d1, tbl[i].ra1[4:0], tbl[i].ra2[4:0]);
      @(negedge clk);
      chk($sformatf("t%0d.we", i),     {31'b0, RegWrite}, tbl[i].we);
      chk($sformatf("t%0d.waddr", i),  {27'b0, write_reg_address}, tbl[i].wa);
      chk($sformatf("t%0d.wdata", i),  write_data, tbl[i].wd);
      chk($sformatf("t%0d.ready0", i), {31'b0, req0_ready}, tbl[i].r0);
      chk($sformatf("t%0d.ready1", i), {31'b0, req1_ready}, tbl[i].r1);
      chk($sformatf("t%0d.haz1", i),   {31'b0, hazard_1}, tbl[i].h1);
      chk($sformatf("t%0d.haz2", i),   {31'b0, hazard_2}, tbl[i].h2);
      chk($sformatf("t%0d.busy", i),   {31'b0, busy}, tbl[i].bz);
      tick();
    end

    // Back-to-back stream on requester 0: addr c+1 handed off in cycle c,
    // visible on the port two cycles later with no gaps.
    for (int c = 0; c < 11; c++) begin
      drive(1'b0, (c < 8), 5'(c + 1), 32'(100 + c), 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
      @(negedge clk);
      check_model("stream");
      if (c < 8) chk("stream.ready0", {31'b0, req0_ready}, 32'd1);
      chk("stream.we_slot", {31'b0, RegWrite}, {31'b0, (c >= 2 && c <= 9)});
      if (c >= 2 && c <= 9) begin
        chk("stream.addr_slot", {27'b0, write_reg_address}, 32'(c - 1));
        chk("stream.data_slot", write_data, 32'(100 + c - 2));
      end
      tick();
    end

    // Both requesters stream six writes each after a fresh reset.
    drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    @(negedge clk);
    tick();
    i0 = 0;
    i1 = 0;
    for (int cyc = 0; cyc < 40 && wq.size() < 12; cyc++) begin
      drive(1'b0, (i0 < 6), 5'(10 + i0), 32'(1000 + i0),
            (i1 < 6), 5'(20 + i1), 32'(2000 + i1), 5'd0, 5'd0);
      @(negedge clk);
      check_model("rr");
      if (RegWrite === 1'b1) wq.push_back(write_reg_address);
      hs0 = req0_valid & req0_ready;
      hs1 = req1_valid & req1_ready;
      tick();
      if (hs0 === 1'b1) i0++;
      if (hs1 === 1'b1) i1++;
    end
    chk("rr.write_count", 32'(wq.size()), 32'd12);
    for (int k = 0; k < 12; k++) begin
`ifdef RF_ARB_ROUND_ROBIN_EN
      exp_a = (k % 2 == 0) ? 32'(10 + k / 2) : 32'(20 + k / 2);
`else
      exp_a = (k < 6) ? 32'(10 + k) : 32'(20 + k - 6);
`endif
      if (k < wq.size()) chk($sformatf("rr.order%0d", k), {27'b0, wq[k]}, exp_a);
    end

    // Random traffic on a small address range to provoke hazards and overlap.
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 7)), $urandom,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      @(negedge clk);
      check_model("rnd");
      tick();
    end

    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      tick();
    end
    @(negedge clk);
    check_model("drain");
    for (int r = 0; r < 32; r++) begin
      chk($sformatf("rf.x%0d", r), rf_dut[r], rf_ref[r]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_regfile_write_arbiter

`default_nettype wire
